// File: rtl/th_sweep_ctrl.sv
// +----------------------------------------------------------------------------+
// | th_sweep_ctrl: exhaustive BIST sweep of one threshold gate with hysteresis.  |
// | Optional macro TH_SWEEP_STOP_ON_FAIL_EN ends the sweep at the first miss.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module th_sweep_ctrl #(
  parameter int IN_NUM     = 4,
  parameter int THRESH     = 2,
  parameter int SETTLE_CYC = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              th_en,
  output logic [IN_NUM-1:0] th_in,
  input  logic              th_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [7:0]        err_cnt,
  output logic [IN_NUM-1:0] fail_pat,
  output logic [1:0]        fail_phase
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_NULL = 3'd1,
    ST_DATA = 3'd2,
    ST_FULL = 3'd3,
    ST_REL  = 3'd4,
    ST_NEXT = 3'd5,
    ST_FIN  = 3'd6
  } state_t;

  localparam int                c_cnt_w    = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(SETTLE_CYC - 1);
  localparam logic [IN_NUM:0]    c_pat_last = {1'b0, {IN_NUM{1'b1}}};

  state_t              r_state, w_state_nxt;
  logic [c_cnt_w-1:0]  r_cnt, w_cnt_nxt;
  logic [IN_NUM:0]     r_pat, w_pat_nxt;
  logic [7:0]          r_err, w_err_nxt;
  logic [IN_NUM-1:0]   r_fail_pat, w_fail_pat_nxt;
  logic [1:0]          r_fail_phase, w_fail_phase_nxt;
  logic                r_pass, w_pass_nxt;
  logic                r_busy, w_busy_nxt;
  logic                r_done, w_done_nxt;
  logic                r_th_en, w_th_en_nxt;
  logic [IN_NUM-1:0]   r_th_in, w_th_in_nxt;
  logic                r_sync1, r_sync2;
  logic                w_last, w_in_phase, w_expect, w_mismatch;
  logic [1:0]          w_phase_code;

  function automatic logic thresh_met(input logic [IN_NUM-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < IN_NUM; i++) n += int'(v[i]);
    return (n >= THRESH);
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_pat        <= '0;
      r_err        <= '0;
      r_fail_pat   <= '0;
      r_fail_phase <= '0;
      r_pass       <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_th_en      <= 1'b0;
      r_th_in      <= '0;
      r_sync1      <= 1'b0;
      r_sync2      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_pat        <= w_pat_nxt;
      r_err        <= w_err_nxt;
      r_fail_pat   <= w_fail_pat_nxt;
      r_fail_phase <= w_fail_phase_nxt;
      r_pass       <= w_pass_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
      r_th_en      <= w_th_en_nxt;
      r_th_in      <= w_th_in_nxt;
      r_sync1      <= th_out;
      r_sync2      <= r_sync1;
    end
  end

  // Expected gate output at the end of each phase; REL relies on hysteresis.
  always_comb begin
    w_expect     = 1'b0;
    w_phase_code = 2'd0;
    w_in_phase   = 1'b1;
    case (r_state)
      ST_NULL: begin w_expect = 1'b0;                          w_phase_code = 2'd0; end
      ST_DATA: begin w_expect = thresh_met(r_pat[IN_NUM-1:0]); w_phase_code = 2'd1; end
      ST_FULL: begin w_expect = 1'b1;                          w_phase_code = 2'd2; end
      ST_REL:  begin w_expect = 1'b1;                          w_phase_code = 2'd3; end
      default: w_in_phase = 1'b0;
    endcase
  end

  assign w_last     = (r_cnt == c_cnt_last);
  assign w_mismatch = w_in_phase && w_last && (r_sync2 != w_expect);

  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_pat_nxt        = r_pat;
    w_err_nxt        = r_err;
    w_fail_pat_nxt   = r_fail_pat;
    w_fail_phase_nxt = r_fail_phase;
    w_pass_nxt       = r_pass;
    w_busy_nxt       = r_busy;
    w_done_nxt       = 1'b0;
    w_th_en_nxt      = 1'b0;
    w_th_in_nxt      = '0;

    if (w_mismatch) begin
      if (r_err != 8'hFF) w_err_nxt = r_err + 8'd1;
      if (r_err == 8'd0) begin
        w_fail_pat_nxt   = r_pat[IN_NUM-1:0];
        w_fail_phase_nxt = w_phase_code;
      end
    end

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_busy_nxt       = 1'b1;
          w_err_nxt        = '0;
          w_pass_nxt       = 1'b0;
          w_fail_pat_nxt   = '0;
          w_fail_phase_nxt = '0;
          w_pat_nxt        = (IN_NUM + 1)'(1);
          w_cnt_nxt        = '0;
          w_state_nxt      = ST_NULL;
        end
      end
      ST_NULL, ST_DATA, ST_FULL, ST_REL: begin
        w_cnt_nxt = r_cnt + c_cnt_w'(1);
        if (w_last) begin
          w_cnt_nxt = '0;
          case (r_state)
            ST_NULL: w_state_nxt = ST_DATA;
            ST_DATA: w_state_nxt = ST_FULL;
            ST_FULL: w_state_nxt = ST_REL;
            default: w_state_nxt = ST_NEXT;
          endcase
        end
      end
      ST_FIN: begin
        w_done_nxt  = 1'b1;
        w_busy_nxt  = 1'b0;
        w_pass_nxt  = (r_err == 8'd0);
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // NEXT takes no cycle of its own: it is resolved on the REL exit edge.
    if (w_state_nxt == ST_NEXT) begin
      if (r_pat == c_pat_last) begin
        w_state_nxt = ST_FIN;
      end else begin
        w_pat_nxt   = r_pat + (IN_NUM + 1)'(1);
        w_state_nxt = ST_NULL;
      end
    end

`ifdef TH_SWEEP_STOP_ON_FAIL_EN
    if (w_mismatch && (r_err == 8'd0)) begin
      w_state_nxt = ST_FIN;
      w_cnt_nxt   = '0;
    end
`endif

    case (w_state_nxt)
      ST_NULL: begin w_th_en_nxt = 1'b1; w_th_in_nxt = '0;                    end
      ST_DATA: begin w_th_en_nxt = 1'b1; w_th_in_nxt = w_pat_nxt[IN_NUM-1:0]; end
      ST_FULL: begin w_th_en_nxt = 1'b1; w_th_in_nxt = '1;                    end
      ST_REL:  begin w_th_en_nxt = 1'b1; w_th_in_nxt = w_pat_nxt[IN_NUM-1:0]; end
      default: begin w_th_en_nxt = 1'b0; w_th_in_nxt = '0;                    end
    endcase
  end

  assign th_en      = r_th_en;
  assign th_in      = r_th_in;
  assign busy       = r_busy;
  assign done       = r_done;
  assign pass       = r_pass;
  assign err_cnt    = r_err;
  assign fail_pat   = r_fail_pat;
  assign fail_phase = r_fail_phase;

endmodule

`default_nettype wire

// File: tb/tb_th_sweep_ctrl.sv
// +----------------------------------------------------------------------------+
// | tb_th_sweep_ctrl: directed sweeps of th_sweep_ctrl against behavioural gates.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_th_sweep_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic       th_en;
  logic [3:0] th_in;
  logic       th_out;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] err_cnt;
  logic [3:0] fail_pat;
  logic [1:0] fail_phase;

  int mode;
  int cyc;
  int total;
  int passed;
  logic h_q;

  typedef struct {
    int         lat;
    logic [7:0] err;
    logic       pass;
    logic [3:0] fpat;
    logic [1:0] fph;
  } exp_t;

  exp_t sb[$];

  th_sweep_ctrl #(.IN_NUM(4), .THRESH(2), .SETTLE_CYC(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .th_en      (th_en),
    .th_in      (th_in),
    .th_out     (th_out),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .err_cnt    (err_cnt),
    .fail_pat   (fail_pat),
    .fail_phase (fail_phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Gate models: 0 = hysteretic TH gate, 1 = output stuck low, 2 = plain threshold.
  initial h_q = 1'b0;
  always @(th_en or th_in) begin
    if (!th_en)                 h_q = 1'b0;
    else if ($countones(th_in) >= 2) h_q = 1'b1;
    else if (th_in == 4'h0)     h_q = 1'b0;
  end
  assign th_out = (mode == 0) ? h_q :
                  (mode == 1) ? 1'b0 :
                  (th_en && ($countones(th_in) >= 2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic exp_t predict(input int m);
    exp_t e;
    logic h, g, r;
    logic [3:0] v;
    int pc;
    e.lat = 481; e.err = 8'd0; e.pass = 1'b0; e.fpat = 4'h0; e.fph = 2'd0;
    h = 1'b0;
    for (int p = 1; p < 16; p++) begin
      pc = $countones(4'(p));
      for (int ph = 0; ph < 4; ph++) begin
        v = (ph == 0) ? 4'h0 : (ph == 2) ? 4'hF : 4'(p);
        if ($countones(v) >= 2) h = 1'b1;
        else if (v == 4'h0)     h = 1'b0;
        case (m)
          0:       g = h;
          1:       g = 1'b0;
          default: g = ($countones(v) >= 2);
        endcase
        r = (ph == 0) ? 1'b0 : (ph == 1) ? (pc >= 2) : 1'b1;
        if (g !== r) begin
          if (e.err == 8'd0) begin
            e.fpat = 4'(p);
            e.fph  = 2'(ph);
          end
          e.err = e.err + 8'd1;
        end
      end
    end
    e.pass = (e.err == 8'd0);
    return e;
  endfunction

  task automatic run_sweep(input int m, input bit reassert);
    exp_t e;
    int k, rel, busy_n;
    bit seen;
    mode = m;
    sb.push_back(predict(m));
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    k = cyc; rel = 0; seen = 1'b0;
    chk("busy_at_start", 32'(busy), 32'd1);
    busy_n = busy ? 1 : 0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      start = reassert && (i == 9 || i == 299);
      @(posedge clk); #1;
      rel = cyc - k;
      if (rel == 1)  begin chk("en_null", 32'(th_en), 32'd1); chk("in_null", 32'(th_in), 32'h0); end
      if (rel == 9)  chk("in_data", 32'(th_in), 32'h1);
      if (rel == 17) chk("in_full", 32'(th_in), 32'hF);
      if (rel == 25) chk("in_rel",  32'(th_in), 32'h1);
      if (done) seen = 1'b1;
      else if (busy) busy_n++;
    end
    start = 1'b0;
    e = sb.pop_front();
    if (!seen) begin
      chk("done_timeout", 32'd0, 32'd1);
    end else begin
      chk("done_latency", 32'(rel),    32'(e.lat));
      chk("busy_cycles",  32'(busy_n), 32'(e.lat));
      chk("busy_at_done", 32'(busy),   32'd0);
      chk("en_at_done",   32'(th_en),  32'd0);
      chk("err_cnt",      32'(err_cnt),    32'(e.err));
      chk("pass",         32'(pass),       32'(e.pass));
      chk("fail_pat",     32'(fail_pat),   32'(e.fpat));
      chk("fail_phase",   32'(fail_phase), 32'(e.fph));
      @(posedge clk); #1;
      chk("done_one_cycle", 32'(done), 32'd0);
      chk("pass_held",      32'(pass), 32'(e.pass));
    end
  endtask

  task automatic abort_sweep();
    int k;
    mode = 1;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    k = cyc;
    for (int i = 0; i < 300 && (cyc - k) < 200; i++) begin
      @(posedge clk); #1;
    end
    chk("abort_err_nonzero", 32'(err_cnt != 8'd0), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("abort_th_en", 32'(th_en),   32'd0);
    chk("abort_th_in", 32'(th_in),   32'h0);
    chk("abort_busy",  32'(busy),    32'd0);
    chk("abort_err",   32'(err_cnt), 32'd0);
    chk("abort_done",  32'(done),    32'd0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("abort_no_done", 32'(done), 32'd0);
    end
    @(negedge clk); rst = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      chk("idle_after_rst", 32'(busy | done), 32'd0);
    end
  endtask

  initial begin
    total = 0; passed = 0;
    mode = 0; rst = 1'b0; start = 1'b0;
    #12;
    chk("rst_th_en",      32'(th_en),      32'd0);
    chk("rst_th_in",      32'(th_in),      32'h0);
    chk("rst_busy",       32'(busy),       32'd0);
    chk("rst_done",       32'(done),       32'd0);
    chk("rst_pass",       32'(pass),       32'd0);
    chk("rst_err_cnt",    32'(err_cnt),    32'd0);
    chk("rst_fail_pat",   32'(fail_pat),   32'h0);
    chk("rst_fail_phase", 32'(fail_phase), 32'd0);
    @(negedge clk); rst = 1'b1;

    run_sweep(0, 1'b0);
    run_sweep(1, 1'b0);
    run_sweep(2, 1'b0);
    run_sweep(0, 1'b1);
    abort_sweep();
    run_sweep(0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
